// File: rtl/c1541_flux_decoder_if.sv
// Signal bundle between the track stage / drive logic and the flux decoder.
interface c1541_flux_decoder_if;
  logic       flux_in;
  logic [1:0] speed_zone;
  logic       mtr;
  logic       mode;
  logic       soe;
  logic [7:0] data;
  logic       byte_ready;
  logic       sync_n;
  logic       bit_ce;

  modport master (
    output flux_in, speed_zone, mtr, mode, soe,
    input  data, byte_ready, sync_n, bit_ce
  );

  modport slave (
    input  flux_in, speed_zone, mtr, mode, soe,
    output data, byte_ready, sync_n, bit_ce
  );
endinterface

// File: rtl/c1541_flux_decoder.sv
// Recovers bit cells from flux pulses, detects SYNC (ten ones) and frames GCR bytes after it.
module c1541_flux_decoder (
  input  logic                 clk,
  input  logic                 reset,
  c1541_flux_decoder_if.slave  bus
);
  logic       r_flux_q;
  logic [6:0] r_phase;
  logic       r_seen;
  // Only the nine most recent bits plus the incoming one are ever examined.
  logic [8:0] r_shift;
  logic [2:0] r_bit_count;
  logic [7:0] r_data;
  logic       r_byte_ready;
  logic       r_sync_n;

  logic [7:0] w_cell_len;
  logic [6:0] w_cell_last;
  logic [6:0] w_half_last;
  logic       w_flux_edge;
  logic       w_strobe;
  logic       w_bit;
  logic       w_sync_next;

  // L = 8*(16 - zone): 128, 120, 112, 104.
  assign w_cell_len  = 8'd128 - {3'd0, bus.speed_zone, 3'd0};
  assign w_cell_last = w_cell_len[6:0] - 7'd1;
  assign w_half_last = w_cell_len[7:1] - 7'd1;

  assign w_flux_edge = bus.flux_in & ~r_flux_q;
  assign w_strobe    = bus.mtr & ~w_flux_edge & (r_phase == w_half_last);
  assign w_bit       = r_seen;
  assign w_sync_next = bus.mode & (&{r_shift, w_bit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flux_q <= 1'b0;
      r_phase  <= 7'd0;
      r_seen   <= 1'b0;
    end else begin
      r_flux_q <= bus.flux_in;
      if (!bus.mtr) begin
        r_phase <= 7'd0;
        r_seen  <= 1'b0;
      end else if (w_flux_edge) begin
        r_phase <= 7'd0;
        r_seen  <= 1'b1;
      end else begin
        r_phase <= (r_phase == w_cell_last) ? 7'd0 : r_phase + 7'd1;
        if (w_strobe) begin
          r_seen <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift      <= '0;
      r_bit_count  <= 3'd0;
      r_data       <= 8'd0;
      r_byte_ready <= 1'b0;
      r_sync_n     <= 1'b1;
    end else begin
      r_byte_ready <= 1'b0;
      if (!bus.mtr) begin
        r_shift     <= '0;
        r_bit_count <= 3'd0;
        r_sync_n    <= 1'b1;
      end else if (w_strobe) begin
        r_shift  <= {r_shift[7:0], w_bit};
        r_sync_n <= ~w_sync_next;
        // While sync persists the counter is pinned, so the first 0 becomes bit 0 of a byte.
        if (w_sync_next) begin
          r_bit_count <= 3'd0;
        end else if (r_bit_count == 3'd7) begin
          r_data       <= {r_shift[6:0], w_bit};
          r_bit_count  <= 3'd0;
          r_byte_ready <= bus.soe;
        end else begin
          r_bit_count <= r_bit_count + 3'd1;
        end
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.byte_ready = r_byte_ready & bus.mtr;
  assign bus.sync_n     = r_sync_n | ~bus.mode | ~bus.mtr;
  assign bus.bit_ce     = w_strobe;
endmodule
